// File: rtl/alu_share_arbiter.sv
// ----------------------------------------------------------------------------
// alu_share_arbiter
// Shares one external combinational ALU (AND/OR/ADD/SUB) between two
// requesters. Round-robin grant, operands latched on accept, result latched
// at the end of the single ISSUE cycle and held until the response handshake.
//
// Ports:
//   clk, reset (async, active-low)
//   req{0,1}_valid/ready/a/b/op   request channels (ready combinational, IDLE only)
//   rsp{0,1}_valid/ready/result/zero/err  response channels
//   alu_a, alu_b, alu_ctrl        operands/control to the shared ALU (0 outside ISSUE)
//   alu_result, alu_zero          shared ALU outputs
//   grant0_cnt, grant1_cnt, conflict_cnt  only with ALU_SHARE_STATS_EN defined
//
// Optional feature macro: ALU_SHARE_STATS_EN (saturating 16-bit statistics).
// ----------------------------------------------------------------------------
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned OP_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic             rsp0_zero,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic             rsp1_zero,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OP_W-1:0]  alu_ctrl,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]      grant0_cnt,
  output logic [15:0]      grant1_cnt,
  output logic [15:0]      conflict_cnt
`endif
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // op[2] set marks an illegal operation
  localparam int unsigned ERR_BIT = 2;

  logic [1:0]       state, state_d;
  logic             last_grant;
  logic             owner;
  logic [WIDTH-1:0] a_q, b_q, result_q;
  logic [OP_W-1:0]  op_q;
  logic             zero_q, err_q;

  logic             in_idle, in_issue, in_resp;
  logic             gnt0, gnt1, accept, rsp_done;

  assign in_idle  = (state == ST_IDLE);
  assign in_issue = (state == ST_ISSUE);
  assign in_resp  = (state == ST_RESP);

  // Round-robin: on a tie the requester that did not win last time gets it
  assign gnt1   = in_idle && req1_valid && (!req0_valid || !last_grant);
  assign gnt0   = in_idle && req0_valid && !gnt1;
  assign accept = gnt0 || gnt1;

  // Ready is forced low while reset is asserted so every output reads 0
  assign req0_ready = reset && gnt0;
  assign req1_ready = reset && gnt1;

  assign rsp_done = in_resp && (owner ? rsp1_ready : rsp0_ready);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state;
    unique case (state)
      ST_IDLE:  if (accept)   state_d = ST_ISSUE;
      ST_ISSUE:               state_d = ST_RESP;
      ST_RESP:  if (rsp_done) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Operand latch on accept, result capture at the end of ISSUE
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant <= 1'b1;
      owner      <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      result_q   <= '0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= gnt1;
        last_grant <= gnt1;
        a_q        <= gnt1 ? req1_a  : req0_a;
        b_q        <= gnt1 ? req1_b  : req0_b;
        op_q       <= gnt1 ? req1_op : req0_op;
      end
      if (in_issue) begin
        if (op_q[ERR_BIT]) begin
          result_q <= '0;
          zero_q   <= 1'b0;
          err_q    <= 1'b1;
        end else begin
          result_q <= alu_result;
          zero_q   <= alu_zero;
          err_q    <= 1'b0;
        end
      end
    end
  end

  // Shared ALU drive; an illegal op never reaches alu_ctrl
  assign alu_a    = in_issue ? a_q : '0;
  assign alu_b    = in_issue ? b_q : '0;
  assign alu_ctrl = (in_issue && !op_q[ERR_BIT]) ? op_q : '0;

  // Responses go only to the owner of the current operation
  assign rsp0_valid  = in_resp && !owner;
  assign rsp1_valid  = in_resp && owner;
  assign rsp0_result = rsp0_valid ? result_q : '0;
  assign rsp1_result = rsp1_valid ? result_q : '0;
  assign rsp0_zero   = rsp0_valid && zero_q;
  assign rsp1_zero   = rsp1_valid && zero_q;
  assign rsp0_err    = rsp0_valid && err_q;
  assign rsp1_err    = rsp1_valid && err_q;

`ifdef ALU_SHARE_STATS_EN
  // Saturating grant and conflict statistics
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grant0_cnt   <= '0;
      grant1_cnt   <= '0;
      conflict_cnt <= '0;
    end else begin
      if (gnt0 && grant0_cnt != 16'hFFFF)
        grant0_cnt <= grant0_cnt + 16'd1;
      if (gnt1 && grant1_cnt != 16'hFFFF)
        grant1_cnt <= grant1_cnt + 16'd1;
      if (in_idle && req0_valid && req1_valid && conflict_cnt != 16'hFFFF)
        conflict_cnt <= conflict_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational 4-op ALU (AND/OR/ADD/SUB, 3-bit control, result plus zero flag) between two requesters, e.g. the EX-stage and a multi-cycle helper unit.
- Per-requester valid/ready request and response channels.
- Round-robin grant, registered operands and result.
- The ALU is instantiated outside this block and wired to the alu_* ports.

Parameters:
- WIDTH, 32, operand/result width.
- OP_W, 3, ALU control width; legal ops are 3'b000 AND, 3'b001 OR, 3'b010 ADD, 3'b011 SUB.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- req0_valid / req1_valid  input  1  request pending.
- req0_ready / req1_ready  output  1  request accepted this cycle.
- req0_a, req0_b / req1_a, req1_b  input  WIDTH  operands.
- req0_op / req1_op  input  OP_W  ALU operation.
- rsp0_valid / rsp1_valid  output  1  response available.
- rsp0_ready / rsp1_ready  input  1  requester takes response.
- rsp0_result / rsp1_result  output  WIDTH  result.
- rsp0_zero / rsp1_zero  output  1  result==0 flag.
- rsp0_err / rsp1_err  output  1  illegal op (op[2]=1).
- alu_a, alu_b  output  WIDTH  operands to shared ALU.
- alu_ctrl  output  OP_W  control to shared ALU.
- alu_result  input  WIDTH  ALU result.
- alu_zero  input  1  ALU zero flag.

Behaviour:
- FSM states IDLE, ISSUE, RESP. Reset state is IDLE.
- Reset values: all outputs 0; last_grant=1, so req0 wins the first tie.
- IDLE: reqN_ready is combinational and is 1 only for the granted requester.
  - Grant goes to the sole valid requester.
  - If both are valid, grant goes to the requester not equal to last_grant.
  - On valid&&ready: latch a, b, op and owner; last_grant<=owner; go to ISSUE.
  - Both ready outputs are 0 in ISSUE and RESP.
- ISSUE (exactly 1 cycle): alu_a/alu_b/alu_ctrl driven from the latched registers. At the clock edge capture result/zero, then go to RESP.
  - Legal op: capture alu_result and alu_zero; err=0.
  - Illegal op (op[2]=1): capture result=0, zero=0, err=1; ALU output ignored.
- RESP: rsp<owner>_valid=1 with the registered result/zero/err; the other rsp_valid stays 0.
  - Values are held stable while rsp_ready=0.
  - On rsp_valid&&rsp_ready, go to IDLE.
- Outside ISSUE, alu_a=0, alu_b=0, alu_ctrl=3'b000.
- Latency: accept at cycle T, rsp_valid at T+2. Throughput is at most one op per 3 cycles.
- Request inputs are sampled only in the accept cycle; later changes are ignored.
- Simultaneous events:
  - A request that arrives during ISSUE/RESP waits; it is not dropped, and the requester holds valid.
  - If both requesters stay valid, grants alternate 0,1,0,1.
- Arithmetic wraps modulo 2^WIDTH; ADD/SUB overflow is not flagged.
- Reset asserted mid-operation: immediate return to IDLE; the pending response is discarded; all outputs 0; last_grant=1.

Optional Feature:
- Macro ALU_SHARE_STATS_EN.
- When defined, three extra outputs exist:
  - grant0_cnt [15:0]: increments on each req0 accept.
  - grant1_cnt [15:0]: increments on each req1 accept.
  - conflict_cnt [15:0]: increments on each IDLE cycle where both req valid.
  - All three saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters do not exist, and the core behaviour is identical.

Test Plan:
- req0 ADD a=5,b=7, rsp0_ready=1: req0_ready at T, rsp0_valid at T+2 with result=12, zero=0, err=0; rsp1_valid stays 0.
- Both valid after reset, req0 SUB 9-9 and req1 OR 0xF0|0x0F: req0 served first (result 0, zero=1), then req1 (result 0xFF).
- Both requesters continuously valid for 6 ops: grant order 0,1,0,1,0,1; each rsp carries the correct result.
- req1 op=3'b101: rsp1_valid at T+2 with err=1, result=0, zero=0; alu_ctrl never equals 3'b101.
- req0 AND 0xFFFF0000&0x0F0F0F0F, rsp0_ready held 0 for 5 cycles: rsp0_result=0x0F0F0000 stable throughout; req1_ready stays 0 until the handshake completes.
- Reset pulsed low during RESP: all outputs 0 next edge; after release, both valid → req0 granted first.
